// File: rtl/urng_pair_sched.sv
// urng_pair_sched: seeds the Tausworthe URNG, skips warm-up, packs (u0,u1) pairs
// and hands them round-robin to NREQ Box-Muller consumers.
// Optional URNG_SCHED_STATS_EN adds pairs_issued / samples_dropped counters.
module urng_pair_sched #(
    parameter int          NREQ   = 2,
    parameter int          WARMUP = 16,
    parameter logic [31:0] DEF_S1 = 32'h0000_1234,
    parameter logic [31:0] DEF_S2 = 32'h0000_5678,
    parameter logic [31:0] DEF_S3 = 32'h0009_ABCD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [31:0]     seed1,
    input  logic [31:0]     seed2,
    input  logic [31:0]     seed3,
    output logic            urng_reset,
    output logic [31:0]     urng_s1,
    output logic [31:0]     urng_s2,
    output logic [31:0]     urng_s3,
    input  logic [31:0]     urng_out,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [31:0]     u0,
    output logic [31:0]     u1,
    output logic            pair_valid,
    output logic            running,
`ifdef URNG_SCHED_STATS_EN
    output logic [31:0]     pairs_issued,
    output logic [31:0]     samples_dropped,
`endif
    output logic [2:0]      seed_err
);

    localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        WARM,
        FILL0,
        FILL1,
        FULL
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [7:0]     cnt;
    logic [RRW-1:0] rr;
    logic [RRW-1:0] rr_nxt;
    logic [RRW-1:0] idx;
    logic           found;
    logic           gnt_ok;
    logic           ok1;
    logic           ok2;
    logic           ok3;

    assign ok1 = seed1 > 32'd1;
    assign ok2 = seed2 > 32'd7;
    assign ok3 = seed3 > 32'd15;

    // URNG is held in seed-load while idle and while seeding
    assign urng_reset = (state == IDLE) || (state == SEED);

    // a pair may only be handed out from FULL, never on an abort cycle
    assign gnt_ok = (state == FULL) && !start && !reset;

    // state register plus a phase counter restarted on every state change
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (start || (state_nxt != state))
                cnt <= '0;
            else
                cnt <= cnt + 8'd1;
        end
    end

    // next-state decode; start aborts from anywhere into a fresh seed
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = IDLE;
            SEED:    if (cnt == 8'd1) state_nxt = WARM;
            WARM:    if (cnt == 8'(WARMUP)) state_nxt = FILL0;
            FILL0:   state_nxt = FILL1;
            FILL1:   state_nxt = FULL;
            FULL:    if (found) state_nxt = FILL0;
            default: state_nxt = IDLE;
        endcase
        if (start)
            state_nxt = SEED;
    end

    // round-robin grant, search begins at rr
    always_comb begin
        gnt    = '0;
        rr_nxt = rr;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = RRW'((int'(rr) + i) % NREQ);
            if (gnt_ok && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                rr_nxt   = RRW'((int'(idx) + 1) % NREQ);
                found    = 1'b1;
            end
        end
    end

    // seed capture with default substitution for weak seeds
    always_ff @(posedge clk) begin
        if (reset) begin
            urng_s1  <= DEF_S1;
            urng_s2  <= DEF_S2;
            urng_s3  <= DEF_S3;
            seed_err <= '0;
        end else if (start) begin
            urng_s1  <= ok1 ? seed1 : DEF_S1;
            urng_s2  <= ok2 ? seed2 : DEF_S2;
            urng_s3  <= ok3 ? seed3 : DEF_S3;
            seed_err <= {~ok3, ~ok2, ~ok1};
        end
    end

    // pair packing, pair ownership and arbitration pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            u0         <= '0;
            u1         <= '0;
            pair_valid <= 1'b0;
            running    <= 1'b0;
            rr         <= '0;
        end else if (start) begin
            pair_valid <= 1'b0;
            running    <= 1'b0;
        end else begin
            if ((state == WARM) && (state_nxt == FILL0))
                running <= 1'b1;
            if (state == FILL0)
                u0 <= urng_out;
            if (state == FILL1) begin
                u1         <= urng_out;
                pair_valid <= 1'b1;
            end
            if (found) begin
                pair_valid <= 1'b0;
                rr         <= rr_nxt;
            end
        end
    end

`ifdef URNG_SCHED_STATS_EN
    // grant and drop statistics, cleared on reset and reseed
    always_ff @(posedge clk) begin
        if (reset || start) begin
            pairs_issued    <= '0;
            samples_dropped <= '0;
        end else if (found) begin
            pairs_issued <= pairs_issued + 32'd1;
        end else if ((state == FULL) &&
                     (samples_dropped != 32'hFFFF_FFFF)) begin
            samples_dropped <= samples_dropped + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_urng_pair_sched.sv
// tb_urng_pair_sched: random req/seed/start traffic against a cycle-count
// model of pair timing, round-robin order and Tausworthe sample selection.
module tb_urng_pair_sched;

    localparam int          N  = 2;
    localparam int          W  = 16;
    localparam logic [31:0] D1 = 32'h0000_1234;
    localparam logic [31:0] D2 = 32'h0000_5678;
    localparam logic [31:0] D3 = 32'h0009_ABCD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   seed1 = '0;
    logic [31:0]   seed2 = '0;
    logic [31:0]   seed3 = '0;
    logic [N-1:0]  req   = '0;
    logic          urng_reset;
    logic [31:0]   urng_s1, urng_s2, urng_s3;
    logic [31:0]   urng_out = '0;
    logic [N-1:0]  gnt;
    logic [31:0]   u0, u1;
    logic          pair_valid, running;
    logic [2:0]    seed_err;

    logic          start_b = 1'b0;
    logic [31:0]   sb1 = '0;
    logic [31:0]   sb2 = '0;
    logic [31:0]   sb3 = '0;
    logic [N-1:0]  req_b = '0;
    logic [31:0]   urng_out_b = '0;
    logic          urng_reset_b;
    logic [31:0]   us1_b, us2_b, us3_b;
    logic [N-1:0]  gnt_b;
    logic [31:0]   u0_b, u1_b;
    logic          pv_b, run_b;
    logic [2:0]    err_b;

`ifdef URNG_SCHED_STATS_EN
    logic [31:0]   pairs_issued, samples_dropped;
    logic [31:0]   pairs_b, drop_b;
`endif

    urng_pair_sched #(.NREQ(N), .WARMUP(W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .seed1(seed1), .seed2(seed2), .seed3(seed3),
        .urng_reset(urng_reset),
        .urng_s1(urng_s1), .urng_s2(urng_s2), .urng_s3(urng_s3),
        .urng_out(urng_out), .req(req), .gnt(gnt),
        .u0(u0), .u1(u1), .pair_valid(pair_valid), .running(running),
`ifdef URNG_SCHED_STATS_EN
        .pairs_issued(pairs_issued), .samples_dropped(samples_dropped),
`endif
        .seed_err(seed_err)
    );

    urng_pair_sched #(.NREQ(N), .WARMUP(0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .seed1(sb1), .seed2(sb2), .seed3(sb3),
        .urng_reset(urng_reset_b),
        .urng_s1(us1_b), .urng_s2(us2_b), .urng_s3(us3_b),
        .urng_out(urng_out_b), .req(req_b), .gnt(gnt_b),
        .u0(u0_b), .u1(u1_b), .pair_valid(pv_b), .running(run_b),
`ifdef URNG_SCHED_STATS_EN
        .pairs_issued(pairs_b), .samples_dropped(drop_b),
`endif
        .seed_err(err_b)
    );

    function automatic logic [95:0] taus(input logic [95:0] s);
        logic [31:0] a, b, c;
        a = s[95:64];
        b = s[63:32];
        c = s[31:0];
        a = ((a & 32'hFFFF_FFFE) << 12) ^ (((a << 13) ^ a) >> 19);
        b = ((b & 32'hFFFF_FFF8) << 4)  ^ (((b << 2)  ^ b) >> 25);
        c = ((c & 32'hFFFF_FFF0) << 17) ^ (((c << 3)  ^ c) >> 11);
        return {a, b, c};
    endfunction

    function automatic logic [31:0] xo(input logic [95:0] s);
        return s[95:64] ^ s[63:32] ^ s[31:0];
    endfunction

    // k-th output after seeding (k=1 is the first fresh sample)
    function automatic logic [31:0] gold(input int k, input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [31:0] c);
        logic [95:0] s;
        s = {a, b, c};
        for (int i = 0; i < k; i++)
            s = taus(s);
        return xo(s);
    endfunction

    // external URNG: loads seeds while held in reset, steps otherwise
    logic [95:0] ts = '0;
    always @(posedge clk) begin
        if (urng_reset) begin
            ts <= {urng_s1, urng_s2, urng_s3};
        end else begin
            ts       <= taus(ts);
            urng_out <= xo(taus(ts));
        end
    end

    // cycles since the last start edge, per instance
    int t   = 0;
    int t_b = 0;
    always @(posedge clk) begin
        t   <= (reset || start)   ? 0 : t + 1;
        t_b <= (reset || start_b) ? 0 : t_b + 1;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h (t=%0d)", tag, got, exp, t);
    endtask

    bit           started, pv_m, sb;
    int           rr_m, nrise, gi, drop_m, pairs_m;
    logic [31:0]  es1, es2, es3, eb1, eb2, eb3, eu0, eu1;
    logic [2:0]   err_m, errb_m;
    logic [N-1:0] eg;

    // reference model: checks last edge's outcome, then books this cycle
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                started = 0; pv_m = 0; sb = 0;
                rr_m = 0; nrise = 1 << 30;
                drop_m = 0; pairs_m = 0;
                es1 = D1; es2 = D2; es3 = D3;
                eb1 = D1; eb2 = D2; eb3 = D3;
                err_m = '0; errb_m = '0;
                eu0 = '0; eu1 = '0;
            end else begin
                if (started && !pv_m && t == nrise) begin
                    pv_m = 1;
                    eu0  = gold(t - 4, es1, es2, es3);
                    eu1  = gold(t - 3, es1, es2, es3);
                end
                eg = '0;
                gi = -1;
                if (pv_m && !start) begin
                    for (int i = 0; i < N; i++)
                        if (gi < 0 && req[(rr_m + i) % N])
                            gi = (rr_m + i) % N;
                    if (gi >= 0)
                        eg[gi] = 1'b1;
                end
                check("gnt", 32'(gnt), 32'(eg));
                check("pair_valid", 32'(pair_valid), 32'(pv_m));
                check("running", 32'(running), 32'(started && t >= W + 3));
                check("urng_reset", 32'(urng_reset), 32'(!started || t < 2));
                check("urng_s1", urng_s1, es1);
                check("urng_s2", urng_s2, es2);
                check("urng_s3", urng_s3, es3);
                check("seed_err", 32'(seed_err), 32'(err_m));
                if (pv_m || !started) begin
                    check("u0", u0, eu0);
                    check("u1", u1, eu1);
                end
                check("b_pair_valid", 32'(pv_b), 32'(sb && t_b >= 5));
                check("b_running", 32'(run_b), 32'(sb && t_b >= 3));
                check("b_urng_reset", 32'(urng_reset_b), 32'(!sb || t_b < 2));
                check("b_seed_err", 32'(err_b), 32'(errb_m));
                check("b_s1", us1_b, eb1);
                check("b_s2", us2_b, eb2);
                check("b_s3", us3_b, eb3);
                check("b_gnt", 32'(gnt_b), 32'd0);
                check("b_u0", u0_b, 32'd0);
                check("b_u1", u1_b, 32'd0);
`ifdef URNG_SCHED_STATS_EN
                check("pairs_issued", pairs_issued, 32'(pairs_m));
                check("samples_dropped", samples_dropped, 32'(drop_m));
                check("b_pairs", pairs_b, 32'd0);
                check("b_dropped", drop_b,
                      32'((sb && t_b > 5) ? t_b - 5 : 0));
`endif
                if (start) begin
                    started = 1; pv_m = 0; nrise = W + 5;
                    drop_m = 0; pairs_m = 0;
                    es1 = (seed1 > 1)  ? seed1 : D1;
                    es2 = (seed2 > 7)  ? seed2 : D2;
                    es3 = (seed3 > 15) ? seed3 : D3;
                    err_m = {seed3 <= 15, seed2 <= 7, seed1 <= 1};
                end else if (gi >= 0) begin
                    pv_m = 0;
                    nrise = t + 3;
                    rr_m = (gi + 1) % N;
                    pairs_m++;
                end else if (pv_m) begin
                    drop_m++;
                end
                if (start_b) begin
                    sb = 1;
                    eb1 = (sb1 > 1)  ? sb1 : D1;
                    eb2 = (sb2 > 7)  ? sb2 : D2;
                    eb3 = (sb3 > 15) ? sb3 : D3;
                    errb_m = {sb3 <= 15, sb2 <= 7, sb1 <= 1};
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c);
        seed1 = a;
        seed2 = b;
        seed3 = c;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    function automatic logic [31:0] rseed(input int lim);
        if ($urandom_range(0, 3) == 0)
            return 32'($urandom_range(0, 2 * lim));
        return $urandom;
    endfunction

    initial begin
        repeat (3) cyc();
        reset = 1'b0;
        repeat (3) cyc();

        // weak seeds, long hold in FULL, then both requesters
        req = '0;
        go(32'd1, 32'd2, 32'd3);
        repeat (25) cyc();
        req = 2'b11;
        repeat (15) cyc();

        // reseed from FULL with good seeds, requesters held
        go(32'hDEAD_BEEF, 32'h0000_1000, 32'h0000_2000);
        repeat (40) cyc();
        req = '0;
        repeat (12) cyc();

        // start lands on the first grant cycle
        req = 2'b11;
        go($urandom, 32'h100, 32'h200);
        repeat (21) cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (30) cyc();

        // random traffic with occasional restarts
        for (int s = 0; s < 5; s++) begin
            go(rseed(1), rseed(7), rseed(15));
            for (int c = 0; c < 70; c++) begin
                req   = 2'($urandom_range(0, 3));
                start = ($urandom_range(0, 39) == 0);
                if (start) begin
                    seed1 = rseed(1);
                    seed2 = rseed(7);
                    seed3 = rseed(15);
                end
                cyc();
            end
            start = 1'b0;
        end

        // reset with start also high while filling u1
        req = '0;
        go(32'h55, 32'h66, 32'h77);
        repeat (20) cyc();
        reset = 1'b1;
        start = 1'b1;
        cyc();
        reset = 1'b0;
        start = 1'b0;
        repeat (5) cyc();

        // zero warm-up instance
        sb1 = 32'd0; sb2 = 32'd8; sb3 = 32'd16;
        start_b = 1'b1;
        cyc();
        start_b = 1'b0;
        repeat (8) cyc();
        sb1 = 32'd2;
        start_b = 1'b1;
        cyc();
        start_b = 1'b0;
        repeat (8) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/urng_pair_sched.md
Name: urng_pair_sched

Overview:
- Sequencer and arbiter for the Tausworthe uniform RNG used by the Box-Muller AWGN path.
- Seeds the URNG through its reset/seed inputs, discards a programmable warm-up run, then packs consecutive 32-bit URNG outputs into (u0,u1) pairs.
- Shares pairs among NREQ Box-Muller consumers with a round-robin req/gnt handshake.
- Sits between the URNG instance and the log/sqrt/cos datapath front-ends.

Parameters:
- NREQ, 2, number of requesters (1..8).
- WARMUP, 16, URNG samples discarded after seeding (0..255).
- DEF_S1, 32'h0000_1234, substitute seed when seed1 invalid.
- DEF_S2, 32'h0000_5678, substitute seed when seed2 invalid.
- DEF_S3, 32'h0009_ABCD, substitute seed when seed3 invalid.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse: latch seeds and (re)seed URNG
- seed1  in  32  requested seed for component 1
- seed2  in  32  requested seed for component 2
- seed3  in  32  requested seed for component 3
- urng_reset  out  1  drives URNG reset (seed load)
- urng_s1  out  32  seed to URNG s1
- urng_s2  out  32  seed to URNG s2
- urng_s3  out  32  seed to URNG s3
- urng_out  in  32  URNG sample, new value every clk cycle
- req  in  NREQ  per-requester pair request, level
- gnt  out  NREQ  one-hot grant, pair consumed in that cycle
- u0  out  32  first uniform of pair
- u1  out  32  second uniform of pair
- pair_valid  out  1  u0/u1 hold an unconsumed pair
- running  out  1  warm-up complete, stream live
- seed_err  out  3  bit i set if seed(i+1) was replaced by its default

Behaviour:
- Clock/reset: one clock, clk; reset synchronous active-high, name reset.
- Reset values: state=IDLE, urng_reset=1, urng_s1..3=DEF_S1..3, gnt=0, u0=u1=0, pair_valid=0, running=0, seed_err=0, rr pointer=0.
- Seed validity: seed1>1, seed2>7, seed3>15; otherwise default substituted and seed_err bit set. Checked and latched only on start.
- States:
  - IDLE: urng_reset=1; no grants; start -> SEED.
  - SEED: urng_reset=1 for exactly 2 cycles, latched seeds on urng_s1..3 -> WARMUP.
  - WARMUP: urng_reset=0; count WARMUP+1 cycles, where the first cycle is the stale post-reset output -> FILL0. running=1 on entry to FILL0.
  - FILL0: u0<=urng_out -> FILL1.
  - FILL1: u1<=urng_out, pair_valid<=1 -> FULL.
  - FULL: wait for a grant; on grant, pair_valid<=0 same edge -> FILL0.
- Latency: first pair_valid at cycle 2+(WARMUP+1)+2 after the start cycle; after a grant, the next pair is valid 2 cycles later.
- URNG is free-running: samples arriving in FULL are dropped, never buffered.
- Arbitration:
  - gnt is combinational from req, state and rr pointer.
  - gnt nonzero only when state==FULL and req!=0.
  - Priority starts at index rr; rr<=(granted index+1) mod NREQ on each grant.
  - A requester must sample u0/u1 in the cycle its gnt is high.
  - Holding req high across grants yields fair alternation between active requesters.
- start in any non-IDLE state: same-edge abort, pair_valid<=0, running<=0, gnt=0 that cycle, seeds re-latched -> SEED. rr is not cleared.
- reset mid-operation overrides start; all outputs return to reset values next edge.
- WARMUP=0: WARMUP lasts exactly 1 cycle.

Optional Feature:
- Macro URNG_SCHED_STATS_EN.
- Defined:
  - Adds outputs pairs_issued[31:0], incremented per grant and wrapping at 2^32.
  - Adds samples_dropped[31:0], incremented each FULL cycle with no grant and saturating at FFFF_FFFF.
  - Both counters cleared by reset and by start.
- Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, then start with seeds 1/2/3, WARMUP=16 -> seed_err=3'b111, urng_s1..3=DEF_S1..3, urng_reset high 2 cycles, first pair_valid 21 cycles after start, u0/u1 equal to golden Tausworthe samples 17 and 18 from default seeds.
- Valid seeds 32'hDEADBEEF/32'h1000/32'h2000, NREQ=2, req=2'b11 held -> gnt sequence 01,10,01,10 every 3 cycles; each pair equals consecutive golden samples, skipping the one sample dropped per FULL cycle.
- req=0 for 10 cycles in FULL -> pair_valid stays 1, u0/u1 unchanged; with stats on, samples_dropped=10.
- start pulse on the grant cycle -> gnt=0 that cycle, pair_valid=0 and running=0 next edge, full reseed sequence repeats.
- reset asserted in FILL1 with start also high -> IDLE, urng_reset=1, all outputs at reset values next edge.
- WARMUP=0, seeds 2/8/16 -> seed_err=0, first pair_valid 5 cycles after start.
